// File: rtl/ifetch_queue_pkg.sv
// rtl/ifetch_queue_pkg.sv - shared constants and helpers for the instruction-fetch front end
//
// Contents:
//   IFQ_DEPTH_DEF     default queue depth
//   IFQ_ADDR_W_DEF    default PC / imem address width
//   IFQ_INSTR_W_DEF   default instruction width
//   IFQ_RESET_PC_DEF  default first fetch address
//   OPC_*             major opcode constants used by control and bypass logic
//   ifq_entry_width   width of one queue entry {pc, instr}
package ifetch_queue_pkg;

    localparam int unsigned IFQ_DEPTH_DEF   = 4;
    localparam int unsigned IFQ_ADDR_W_DEF  = 32;
    localparam int unsigned IFQ_INSTR_W_DEF = 32;
    localparam logic [31:0] IFQ_RESET_PC_DEF = 32'h0000_0000;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    // Queue entries carry the PC alongside the instruction word.
    function automatic int unsigned ifq_entry_width(input int unsigned addr_w,
                                                    input int unsigned instr_w);
        return addr_w + instr_w;
    endfunction

endpackage

// File: rtl/ifetch_queue_fetch_fifo.sv
// rtl/ifetch_queue_fetch_fifo.sv - circular DEPTH x WIDTH entry store with push/pop/flush
//
// Parameters: DEPTH (power of two, >= 2), WIDTH (entry bits)
// Ports:
//   clk_i         clock, rising edge
//   rst_ni        asynchronous active-low reset, empties the store
//   flush_i       empty the store this cycle (overrides push and pop)
//   push_i        write push_data_i at the tail
//   push_data_i   entry to write
//   pop_i         discard the head entry
//   head_data_o   current head entry (meaningless when empty)
//   count_o       number of stored entries, 0..DEPTH
//   empty_o       no entries stored
module ifetch_queue_fetch_fifo
    import ifetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = IFQ_DEPTH_DEF,
    parameter int unsigned WIDTH = 64
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           head_data_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       empty_o
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_i) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop_i) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: entries are only read once the pointers cover them.
    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) begin
            mem_q[wr_ptr_q[IDX_W-1:0]] <= push_data_i;
        end
    end

    assign head_data_o = mem_q[rd_ptr_q[IDX_W-1:0]];
    assign count_o     = wr_ptr_q - rd_ptr_q;
    assign empty_o     = (wr_ptr_q == rd_ptr_q);

endmodule

// File: rtl/ifetch_queue.sv
// rtl/ifetch_queue.sv - instruction-fetch front end: PC, imem requests, decoupling queue to decode
//
// Optional feature macro: IFETCH_BYPASS_EN (a response arriving at an empty queue is
// presented to decode combinationally in the same cycle).
//
// Parameters: ADDR_W, INSTR_W, DEPTH (power of two, >= 2), RESET_PC
// Ports:
//   clk_i             clock, rising edge
//   rst_ni            asynchronous active-low reset
//   imem_req_o        read request this cycle
//   imem_addr_o       read address (current fetch PC)
//   imem_rdata_i      read data, one cycle after the request
//   out_valid_o       head entry available to decode
//   out_ready_i       decode accepts the head entry
//   out_pc_o          PC of the head instruction
//   out_instr_o       head instruction
//   redirect_valid_i  taken branch/jump from execute
//   redirect_pc_i     new fetch PC
//   occupancy_o       queued entries, excluding the in-flight read
module ifetch_queue
    import ifetch_queue_pkg::*;
#(
    parameter int unsigned        ADDR_W   = IFQ_ADDR_W_DEF,
    parameter int unsigned        INSTR_W  = IFQ_INSTR_W_DEF,
    parameter int unsigned        DEPTH    = IFQ_DEPTH_DEF,
    parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(IFQ_RESET_PC_DEF)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    output logic                     imem_req_o,
    output logic [ADDR_W-1:0]        imem_addr_o,
    input  logic [INSTR_W-1:0]       imem_rdata_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [ADDR_W-1:0]        out_pc_o,
    output logic [INSTR_W-1:0]       out_instr_o,
    input  logic                     redirect_valid_i,
    input  logic [ADDR_W-1:0]        redirect_pc_i,
    output logic [$clog2(DEPTH):0]   occupancy_o
);

    localparam int unsigned ENTRY_W = ifq_entry_width(ADDR_W, INSTR_W);
    localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
    logic              inflight_q, inflight_d;
    logic              squash_q, squash_d;

    logic               fifo_push;
    logic               fifo_pop;
    logic [ENTRY_W-1:0] fifo_head;
    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_empty;

    logic               resp_valid;
    logic               bypass_sel;
    logic               pop;
    logic [ENTRY_W-1:0] resp_entry;
    logic [ENTRY_W-1:0] head_entry;
    logic [CNT_W:0]     committed;

    // A response is live when a read was issued last cycle and it was not squashed.
    assign resp_valid = inflight_q & ~squash_q;
    assign resp_entry = {inflight_pc_q, imem_rdata_i};

`ifdef IFETCH_BYPASS_EN
    assign bypass_sel = fifo_empty & resp_valid;
`else
    assign bypass_sel = 1'b0;
`endif

    // Redirect hides the head from decode so a concurrent out_ready cannot pop.
    assign out_valid_o = ~redirect_valid_i & (~fifo_empty | bypass_sel);
    assign head_entry  = bypass_sel ? resp_entry : fifo_head;
    assign {out_pc_o, out_instr_o} = head_entry;

    assign pop      = out_valid_o & out_ready_i;
    assign fifo_pop = pop & ~fifo_empty;

    // A bypassed response that decode takes this cycle never enters storage.
    assign fifo_push = resp_valid & ~redirect_valid_i & ~(bypass_sel & out_ready_i);

    // Entries the queue is committed to hold after this cycle: stored plus the
    // response now arriving, minus what decode takes. Returning the pop credit
    // in the same cycle keeps one fetch per cycle with only DEPTH entries.
    assign committed = {1'b0, fifo_count}
                     + {{CNT_W{1'b0}}, inflight_q}
                     - {{CNT_W{1'b0}}, pop};

    // Gated by reset so no request is seen while the block is held in reset.
    assign imem_req_o  = rst_ni & ~redirect_valid_i & (committed < (CNT_W+1)'(DEPTH));
    assign imem_addr_o = fetch_pc_q;
    assign occupancy_o = fifo_count;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_pc_d = inflight_pc_q;
        inflight_d    = imem_req_o;
        squash_d      = 1'b0;
        if (redirect_valid_i) begin
            fetch_pc_d = redirect_pc_i;
            squash_d   = inflight_q;
        end else if (imem_req_o) begin
            inflight_pc_d = fetch_pc_q;
            fetch_pc_d    = fetch_pc_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fetch_pc_q    <= RESET_PC;
            inflight_pc_q <= '0;
            inflight_q    <= 1'b0;
            squash_q      <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_pc_q <= inflight_pc_d;
            inflight_q    <= inflight_d;
            squash_q      <= squash_d;
        end
    end

    ifetch_queue_fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fetch_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .flush_i     (redirect_valid_i),
        .push_i      (fifo_push),
        .push_data_i (resp_entry),
        .pop_i       (fifo_pop),
        .head_data_o (fifo_head),
        .count_o     (fifo_count),
        .empty_o     (fifo_empty)
    );

endmodule

// File: tb/tb_ifetch_queue.sv
// tb/tb_ifetch_queue.sv - randomized bench for ifetch_queue against a queue-level model
module tb_ifetch_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int IW    = 32;

`ifdef IFETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic [IW-1:0] imem_rdata;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_pc;
    logic [IW-1:0] out_instr;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic [2:0]    occupancy;

    always #5 clk = ~clk;

    ifetch_queue #(
        .ADDR_W   (AW),
        .INSTR_W  (IW),
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .imem_req_o       (imem_req),
        .imem_addr_o      (imem_addr),
        .imem_rdata_i     (imem_rdata),
        .out_valid_o      (out_valid),
        .out_ready_i      (out_ready),
        .out_pc_o         (out_pc),
        .out_instr_o      (out_instr),
        .redirect_valid_i (redirect_valid),
        .redirect_pc_i    (redirect_pc),
        .occupancy_o      (occupancy)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return 32'h1000 + a;
    endfunction

    // Reference model: program-order list of fetched-but-unconsumed instructions.
    entry_t      m_q[$];
    logic [31:0] m_pc;
    bit          m_infl;
    logic [31:0] m_infl_pc;
    bit          m_squash;
    // Memory side of the environment: answers whatever address the DUT asked for.
    bit          mem_pend;
    logic [31:0] mem_addr;
    int          req_cnt;

    task automatic model_reset();
        m_q.delete();
        m_pc      = 32'h0;
        m_infl    = 1'b0;
        m_infl_pc = 32'h0;
        m_squash  = 1'b0;
        mem_pend  = 1'b0;
        mem_addr  = 32'h0;
    endtask

    // Called at posedge+1; returns at the next posedge+1.
    task automatic cycle(input bit rdy, input bit rv, input logic [31:0] rpc);
        entry_t head;
        entry_t resp_e;
        bit     resp, byp, exp_valid, pop, exp_req;
        int     occ;
        out_ready      = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        imem_rdata     = mem_pend ? mem_f(mem_addr) : $urandom;
        #1;
        occ          = m_q.size();
        resp         = m_infl && !m_squash;
        resp_e.pc    = m_infl_pc;
        resp_e.instr = mem_f(m_infl_pc);
        byp          = BYP && (occ == 0) && resp && !rv;
        exp_valid    = !rv && (occ > 0 || byp);
        pop          = exp_valid && rdy;
        exp_req      = !rv && ((occ + int'(m_infl) - int'(pop)) < DEPTH);
        check("imem_req", imem_req, exp_req);
        check("imem_addr", imem_addr, m_pc);
        check("out_valid", out_valid, exp_valid);
        check("occupancy", occupancy, occ);
        if (exp_valid) begin
            head = (occ > 0) ? m_q[0] : resp_e;
            check("out_pc", out_pc, head.pc);
            check("out_instr", out_instr, head.instr);
        end
        if (imem_req) req_cnt++;
        mem_pend = imem_req;
        mem_addr = imem_addr;
        if (rv) begin
            m_q.delete();
            m_squash = m_infl;
            m_infl   = 1'b0;
            m_pc     = rpc;
        end else begin
            if (pop && occ > 0) void'(m_q.pop_front());
            if (resp && !(byp && pop)) m_q.push_back(resp_e);
            m_squash = 1'b0;
            m_infl   = exp_req;
            if (exp_req) begin
                m_infl_pc = m_pc;
                m_pc      = m_pc + 32'd1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state();
        check("rst_imem_req", imem_req, 1'b0);
        check("rst_imem_addr", imem_addr, 32'h0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_occupancy", occupancy, 3'd0);
    endtask

    initial begin
        rst_n          = 1'b0;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_rdata     = 32'h0;
        req_cnt        = 0;
        model_reset();
        #12;
        check_reset_state();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Sustained streaming with decode always ready.
        for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, 32'h0);

        // Decode stall: exactly DEPTH requests from a clean start, then drain.
        cycle(1'b0, 1'b1, 32'h0);
        req_cnt = 0;
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 32'h0);
        check("stall_reqs", req_cnt, DEPTH);
        check("stall_occ", occupancy, DEPTH);
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 32'h0);

        // Redirect with entries queued and a read in flight, decode ready.
        cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 32'h40);
        check("redir_occ", occupancy, 3'd0);
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 32'h0);

        // PC wrap at the top of the address space.
        cycle(1'b1, 1'b1, 32'hFFFF_FFFF);
        cycle(1'b1, 1'b0, 32'h0);
        check("wrap_addr", imem_addr, 32'h0);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 32'h0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
                  ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFE : $urandom);
        end

        // Asynchronous reset mid-operation.
        rst_n = 1'b0;
        #1;
        check_reset_state();
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 200; i++) begin
            cycle($urandom_range(0, 1) != 0, $urandom_range(0, 11) == 0, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ifetch_queue.md
# ifetch_queue

Parametrised instruction-fetch front end for the pipelined processor: owns the PC, issues word-addressed reads to instruction memory, and buffers returned instructions with their PCs in a DEPTH-entry queue feeding decode through a valid/ready handshake. It decouples fetch from decode stalls, which the single-latch FD stage could not do. Branch/jump redirects from execute flush the queue and squash any in-flight read.

## Interface
- ADDR_W, 32, PC and imem address width
- INSTR_W, 32, instruction width
- DEPTH, 4, queue entries; power of two, ≥ 2
- RESET_PC, 0, first fetch address after reset

- clock  in  1  master clock, rising edge
- reset  in  1  asynchronous, active-low; clears all state
- imem_req  out  1  read request this cycle
- imem_addr  out  ADDR_W  read address (valid when imem_req)
- imem_rdata  in  INSTR_W  read data, fixed 1-cycle latency after the request
- out_valid  out  1  head entry available to decode
- out_ready  in  1  decode accepts head this cycle
- out_pc  out  ADDR_W  PC of head instruction
- out_instr  out  INSTR_W  head instruction
- redirect_valid  in  1  taken branch/jump from execute
- redirect_pc  in  ADDR_W  new fetch PC
- occupancy  out  log2(DEPTH)+1  queued entries (excludes in-flight)

## Operation
- State: fetch_pc, queue (circular, rd/wr pointers one bit wider than index), inflight flag, inflight_pc, squash flag.
- Pop = out_valid & out_ready.
- Issue rule: imem_req = !redirect_valid & (occupancy + inflight − pop < DEPTH). imem_addr = fetch_pc. On issue: inflight_pc ← fetch_pc, fetch_pc ← fetch_pc + 1 (modulo 2^ADDR_W, wraps silently).
- Response: cycle after an issue, imem_rdata pushed as {inflight_pc, imem_rdata} unless squash set; inflight clears unless a new issue occurs the same cycle.
- Redirect (highest priority): queue emptied, fetch_pc ← redirect_pc, squash ← inflight (response arriving next cycle discarded), out_valid forced 0, imem_req forced 0 that cycle. Concurrent out_ready ignored.
- Push and pop same cycle: both happen; occupancy unchanged. Full queue never receives a push (guaranteed by issue rule).
- Empty queue: out_valid = 0; out_pc/out_instr don't-care.
- Combinational paths: out_ready → imem_req (credit return); redirect_valid → imem_req, out_valid.

## Timing
- Reset values: imem_req 0, imem_addr RESET_PC, out_valid 0, occupancy 0, fetch_pc RESET_PC, inflight 0, squash 0.
- First request in first cycle after reset deasserts.
- Request in cycle t → entry visible on out_* in t+2 (bypass off) or t+1 (bypass on, queue empty).
- Redirect in cycle r → request to redirect_pc in r+1 → out_valid earliest r+3 (r+2 with bypass).
- Sustained throughput with out_ready held high: one instruction per cycle for DEPTH ≥ 2.
- Reset asserted mid-operation: all state cleared asynchronously; pending response dropped.

## Configuration
- IFETCH_BYPASS_EN defined: when queue empty and a non-squashed response arrives, it drives out_* combinationally that cycle; if popped, it is not written to the queue.
- Undefined: every response goes through the queue; out_* driven only from queue storage (registered).

## Structure
- Shared package/header: opcode constants already used by control/bypass, plus DEPTH default, entry width (ADDR_W+INSTR_W), and RESET_PC default.
- One sub-module: fetch_fifo (parametrised DEPTH × width storage, pointers, occupancy, push/pop/flush); PC, credit and squash logic stay in ifetch_queue.

## Test plan
- Reset release, out_ready=1, imem returns 0x1000+addr → out_pc 0,1,2,… one per cycle from cycle 2, out_instr 0x1000,0x1001,…
- out_ready=0 for 10 cycles, DEPTH=4 → exactly 4 requests issued (addr 0–3), occupancy 4, imem_req 0 thereafter; release → 0–3 drained in order, fetch resumes at 4.
- Redirect to 0x40 while inflight at addr 5 with 2 queued → response for 5 discarded, occupancy 0, next request addr 0x40, out_pc 0x40 first accepted.
- Redirect asserted same cycle as pop and push → no pop counted, no push, queue empty next cycle.
- fetch_pc at 0xFFFFFFFF → next request addr 0x00000000.
- With IFETCH_BYPASS_EN, empty queue → out_valid one cycle after request; without it, two cycles.
